// File: rtl/alu.sv
// ALU: ADD/SUB/AND/OR/SLT with combinational flags plus a 1-cycle registered copy of result/flags.
// Optional macro ALU_EXT_OPS_EN adds XOR/SLL/SRL on codes 100/110/111; otherwise those codes give 0.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic [WIDTH-1:0] ALUResultQ,
    output logic             ZeroQ,
    output logic             OverflowQ
);

    localparam int MSB = WIDTH - 1;
`ifdef ALU_EXT_OPS_EN
    localparam int SHW = $clog2(WIDTH);
`endif

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;

    assign sum  = SrcA + SrcB;
    assign diff = SrcA - SrcB;

    // Signed overflow from the sign bits: same-sign inputs for ADD, opposite-sign for SUB.
    assign add_ovf = (SrcA[MSB] == SrcB[MSB]) && (sum[MSB]  != SrcA[MSB]);
    assign sub_ovf = (SrcA[MSB] != SrcB[MSB]) && (diff[MSB] != SrcA[MSB]);
    assign slt     = ($signed(SrcA) < $signed(SrcB));

    always_comb begin
        ALUResult = '0;
        Overflow  = 1'b0;
        unique case (ALUControl)
            3'b000: begin
                ALUResult = sum;
                Overflow  = add_ovf;
            end
            3'b001: begin
                ALUResult = diff;
                Overflow  = sub_ovf;
            end
            3'b010: ALUResult = SrcA & SrcB;
            3'b011: ALUResult = SrcA | SrcB;
            3'b101: ALUResult = {{(WIDTH-1){1'b0}}, slt};
`ifdef ALU_EXT_OPS_EN
            3'b100: ALUResult = SrcA ^ SrcB;
            3'b110: ALUResult = SrcA << SrcB[SHW-1:0];
            3'b111: ALUResult = SrcA >> SrcB[SHW-1:0];
`else
            3'b100, 3'b110, 3'b111: ALUResult = '0;
`endif
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             ovf_d, ovf_q;

    assign result_d = ALUResult;
    assign zero_d   = Zero;
    assign ovf_d    = Overflow;

    // Reset state mirrors a zero result: ZeroQ reads 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ALUResultQ = result_q;
    assign ZeroQ      = zero_q;
    assign OverflowQ  = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, registered-stage sequences, random vs. arithmetic model.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult, ALUResultQ;
    logic        Zero, Overflow, ZeroQ, OverflowQ;

    int errors = 0;
    int checks = 0;

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .ALUResultQ (ALUResultQ),
        .ZeroQ      (ZeroQ),
        .OverflowQ  (OverflowQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain signed/unsigned integer arithmetic on 64-bit values.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0: return 32'((ua + ub) % 64'h1_0000_0000);
            3'd1: return 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
            3'd4: return a ^ b;
            3'd6: return 32'((ua * (64'd1 << (ub % 32))) % 64'h1_0000_0000);
            3'd7: return 32'(ua / (64'd1 << (ub % 32)));
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 3'd0)      s = sa + sb;
        else if (op == 3'd1) s = sa - sb;
        else                 return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[3]  = '{3'd2, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{3'd3, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{3'd5, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
        vecs[7]  = '{3'd5, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{3'd5, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        vecs[9]  = '{3'd5, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[11] = '{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[12] = '{3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
`ifdef ALU_EXT_OPS_EN
        vecs[13] = '{3'd4, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977, 1'b0, 1'b0};
        vecs[14] = '{3'd6, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0};
        vecs[15] = '{3'd7, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0};
`else
        vecs[13] = '{3'd4, 32'h12345678, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{3'd6, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[15] = '{3'd7, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
`endif

        reset = 1'b1;
        apply(3'd0, 32'd7, 32'd9);
        @(posedge clk); #1;
        chk("reset_resultq", ALUResultQ, 32'd0);
        chk("reset_zeroq", {31'd0, ZeroQ}, 32'd1);
        chk("reset_ovfq", {31'd0, OverflowQ}, 32'd0);
        chk("reset_comb_result", ALUResult, 32'd16);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_result", i), ALUResult, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), {31'd0, Zero}, {31'd0, vecs[i].z});
            chk($sformatf("vec%0d_ovf", i), {31'd0, Overflow}, {31'd0, vecs[i].v});
        end

        // Registered stage: capture, then reset wins over capture of a nonzero overflowing result.
        apply(3'd0, 32'd2, 32'd3);
        @(posedge clk); #1;
        chk("q_add_result", ALUResultQ, 32'd5);
        chk("q_add_zero", {31'd0, ZeroQ}, 32'd0);
        apply(3'd0, 32'h7FFFFFFF, 32'd1);
        @(posedge clk); #1;
        chk("q_ovf_set", {31'd0, OverflowQ}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("q_rst_result", ALUResultQ, 32'd0);
        chk("q_rst_zero", {31'd0, ZeroQ}, 32'd1);
        chk("q_rst_ovf", {31'd0, OverflowQ}, 32'd0);
        chk("rst_comb_ovf", {31'd0, Overflow}, 32'd1);
        chk("rst_comb_result", ALUResult, 32'h80000000);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("q_after_rst", ALUResultQ, 32'h80000000);

        // Random: 200 per main op plus a few on the remaining codes; Q checked one edge later.
        for (int k = 0; k < 1060; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b, er;
            logic        ev;
            if (k < 1000) begin
                case (k / 200)
                    0: op = 3'd0;
                    1: op = 3'd1;
                    2: op = 3'd2;
                    3: op = 3'd3;
                    default: op = 3'd5;
                endcase
            end else begin
                case ((k - 1000) % 3)
                    0: op = 3'd4;
                    1: op = 3'd6;
                    default: op = 3'd7;
                endcase
            end
            a = $urandom;
            b = $urandom;
            if (k % 10 == 0) b = a;
            er = ref_res(op, a, b);
            ev = ref_ovf(op, a, b);
            apply(op, a, b);
            chk($sformatf("rnd%0d_op%0d_result", k, op), ALUResult, er);
            chk($sformatf("rnd%0d_op%0d_zero", k, op), {31'd0, Zero}, {31'd0, (er == 32'd0)});
            chk($sformatf("rnd%0d_op%0d_ovf", k, op), {31'd0, Overflow}, {31'd0, ev});
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_resultq", k), ALUResultQ, er);
            chk($sformatf("rnd%0d_zeroq", k), {31'd0, ZeroQ}, {31'd0, (er == 32'd0)});
            chk($sformatf("rnd%0d_ovfq", k), {31'd0, OverflowQ}, {31'd0, ev});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
